// File: rtl/aes_pkg.sv
// Shared AES round-stage types, constants and byte-level helpers.
package aes_pkg;

  localparam int unsigned STATE_W  = 128;
  localparam int unsigned COL_W    = 32;
  localparam logic [7:0]  AES_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // LSB position of state byte s[r][c] (byte 4c+r, byte 0 at the MSB end)
  function automatic int unsigned byte_lsb(input int unsigned r, input int unsigned c);
    return STATE_W - 8 * (4 * c + r + 1);
  endfunction

  function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] sr;
    sr = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[byte_lsb(r, c) +: 8] = s[byte_lsb(r, (c + r) % 4) +: 8];
      end
    end
    return sr;
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// MixColumns on one 32-bit column; row 0 occupies the top byte.
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  // 3*b expressed as xtime(b) ^ b
  assign col_o[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
  assign col_o[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
  assign col_o[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
  assign col_o[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/aes_mix_add_stage.sv
// ShiftRows -> MixColumns (skipped on last round) -> AddRoundKey, as an
// elastic valid/ready pipeline of one or two register stages.
module aes_mix_add_stage
  import aes_pkg::*;
#(
  parameter bit MID_REG = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_block,
  input  logic [STATE_W-1:0] in_round_key,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_block,
  output logic               out_last
);

  logic [STATE_W-1:0] sr_c, mc_c, mixed_c;
  logic               s2_adv_c;
  logic               s2_in_valid_c;
  logic [STATE_W-1:0] s2_in_block_c;
  logic               s2_in_last_c;

  logic               out_valid_q, out_valid_d;
  logic [STATE_W-1:0] out_block_q, out_block_d;
  logic               out_last_q,  out_last_d;

  assign sr_c = shift_rows(in_block);

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_mix_column u_mix_column (
      .col_i (sr_c[STATE_W-1-COL_W*c -: COL_W]),
      .col_o (mc_c[STATE_W-1-COL_W*c -: COL_W])
    );
  end

  assign mixed_c  = in_last ? sr_c : mc_c;
  assign s2_adv_c = !out_valid_q || out_ready;

  if (MID_REG) begin : g_mid
    logic               s1_valid_q, s1_valid_d;
    logic [STATE_W-1:0] s1_state_q, s1_state_d;
    logic [STATE_W-1:0] s1_key_q,   s1_key_d;
    logic               s1_last_q,  s1_last_d;
    logic               s1_adv_c;

    assign s1_adv_c = !s1_valid_q || s2_adv_c;
    // Held low during reset so nothing is offered a handshake then
    assign in_ready = s1_adv_c && !rst;

    always_comb begin
      s1_valid_d = s1_valid_q;
      s1_state_d = s1_state_q;
      s1_key_d   = s1_key_q;
      s1_last_d  = s1_last_q;
      if (s1_adv_c) begin
        s1_valid_d = in_valid;
        if (in_valid) begin
          s1_state_d = mixed_c;
          s1_key_d   = in_round_key;
          s1_last_d  = in_last;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_state_q <= '0;
        s1_key_q   <= '0;
        s1_last_q  <= 1'b0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_state_q <= s1_state_d;
        s1_key_q   <= s1_key_d;
        s1_last_q  <= s1_last_d;
      end
    end

    assign s2_in_valid_c = s1_valid_q;
    assign s2_in_block_c = s1_state_q ^ s1_key_q;
    assign s2_in_last_c  = s1_last_q;
  end else begin : g_nomid
    assign in_ready      = s2_adv_c && !rst;
    assign s2_in_valid_c = in_valid;
    assign s2_in_block_c = mixed_c ^ in_round_key;
    assign s2_in_last_c  = in_last;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_block_d = out_block_q;
    out_last_d  = out_last_q;
    if (s2_adv_c) begin
      out_valid_d = s2_in_valid_c;
      if (s2_in_valid_c) begin
        out_block_d = s2_in_block_c;
        out_last_d  = s2_in_last_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_block_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_block_q <= out_block_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_block = out_block_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_aes_mix_add_stage.sv
// Scoreboarded bench for aes_mix_add_stage (MID_REG=1 main DUT, MID_REG=0 side DUT).
module tb_aes_mix_add_stage;

  typedef struct packed {
    logic [127:0] blk;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_last;
  logic [127:0] in_block, in_round_key;
  logic         out_valid, out_ready, out_last;
  logic [127:0] out_block;
  logic         in_valid0, in_ready0, out_valid0, out_ready0, out_last0;
  logic [127:0] out_block0;

  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  exp_t sb[$];

  localparam logic [127:0] R1_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] R1_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R1_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] RF_IN  = 128'he9098972cb31075f3d327d94af2e2cb5;
  localparam logic [127:0] RF_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RF_OUT = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  aes_mix_add_stage #(.MID_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .in_round_key(in_round_key), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .out_last(out_last)
  );

  aes_mix_add_stage #(.MID_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_block(in_block),
    .in_round_key(in_round_key), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_block(out_block0), .out_last(out_last0)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] b, input logic [127:0] k,
                                         input logic last);
    logic [7:0]   s[4][4];
    logic [7:0]   t[4][4];
    logic [7:0]   u[4];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i % 4][i / 4] = b[127 - 8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = s[r][(c + r) % 4];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) u[r] = t[r][c];
        for (int r = 0; r < 4; r++)
          t[r][c] = gmul(u[r], 8'h02) ^ gmul(u[(r+1)%4], 8'h03) ^ u[(r+2)%4] ^ u[(r+3)%4];
      end
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = t[i % 4][i / 4];
    return res ^ k;
  endfunction

  // Output monitor: a handshake will happen at the next rising edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      pops++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: out_block=%h out_last=%b with empty scoreboard",
                 out_block, out_last);
      end else begin
        e = sb.pop_front();
        if ({out_block, out_last} !== {e.blk, e.last}) begin
          errors++;
          $display("FAIL sb_data: got %h/%b expected %h/%b", out_block, out_last, e.blk, e.last);
        end
      end
    end
  end

  // Entered and left at posedge+1
  task automatic send(input logic [127:0] b, input logic [127:0] k, input logic l,
                      input logic [127:0] eb, input logic el);
    logic done = 1'b0;
    in_block = b; in_round_key = k; in_last = l; in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{blk: eb, last: el});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b required 1 within 50 cycles", in_ready);
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 40 && sb.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, out_block, out_last, in_ready} !== {1'b0, 128'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: valid=%b block=%h last=%b in_ready=%b required 0/0/0/0",
               out_valid, out_block, out_last, in_ready);
    end
    checks++;
    if ({out_valid0, out_block0, in_ready0} !== {1'b0, 128'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state0: valid=%b block=%h in_ready=%b required 0/0/0",
               out_valid0, out_block0, in_ready0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round1();
    out_ready = 1'b1;
    send(R1_IN, R1_KEY, 1'b0, R1_OUT, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL round1_lat1: out_valid=%b required 0 one cycle after handshake", out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_block !== R1_OUT || out_last !== 1'b0) begin
      errors++;
      $display("FAIL round1_lat2: valid=%b block=%h last=%b required 1/%h/0",
               out_valid, out_block, out_last, R1_OUT);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_final_round();
    send(RF_IN, RF_KEY, 1'b1, RF_OUT, 1'b1);
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [127:0] b, k;
    logic         l;
    int           p0 = pops;
    out_ready = 1'b1;
    for (int i = 0; i < 96; i++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      l = (i % 7 == 3);
      in_block = b; in_round_key = k; in_last = l; in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== (i >= 2)) begin
        errors++;
        $display("FAIL stream_flow: i=%0d in_ready=%b out_valid=%b required 1/%b",
                 i, in_ready, out_valid, (i >= 2));
      end
      sb.push_back('{blk: model(b, k, l), last: l});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain();
    checks++;
    if (pops - p0 != 96) begin
      errors++;
      $display("FAIL stream_count: outputs=%0d required 96", pops - p0);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] b[4], k[4], e0;
    int           idx = 0;
    for (int i = 0; i < 4; i++) begin
      b[i] = {$urandom, $urandom, $urandom, $urandom};
      k[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    e0 = model(b[0], k[0], 1'b0);
    for (int cyc = 0; cyc < 15; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        in_block = b[idx]; in_round_key = k[idx]; in_last = 1'b0;
      end
      @(negedge clk);
      if (cyc < 5) begin
        checks++;
        if (in_ready !== (cyc < 2)) begin
          errors++;
          $display("FAIL bp_in_ready: cyc=%0d in_ready=%b required %b", cyc, in_ready, (cyc < 2));
        end
      end
      if (cyc >= 2 && cyc < 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_block !== e0) begin
          errors++;
          $display("FAIL bp_hold: cyc=%0d valid=%b block=%h required 1/%h",
                   cyc, out_valid, out_block, e0);
        end
      end
      if (cyc == 4) begin
        checks++;
        if (idx != 2) begin
          errors++;
          $display("FAIL bp_accepted: accepted=%0d required 2", idx);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{blk: model(b[idx], k[idx], 1'b0), last: 1'b0});
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 4) begin
      errors++;
      $display("FAIL bp_total: accepted=%0d required 4", idx);
    end
    wait_drain();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    in_block = R1_KEY; in_round_key = R1_IN; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_block = RF_IN;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_block, out_last, in_ready} !== {1'b0, 128'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_clear: valid=%b block=%h last=%b in_ready=%b required 0/0/0/0",
               out_valid, out_block, out_last, in_ready);
    end
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    send(R1_IN, R1_KEY, 1'b0, R1_OUT, 1'b0);
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_mid_reg0();
    in_block = R1_IN; in_round_key = R1_KEY; in_last = 1'b0; in_valid0 = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL mr0_accept: in_ready=%b out_valid=%b required 1/0", in_ready0, out_valid0);
    end
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b1 || out_block0 !== R1_OUT || out_last0 !== 1'b0) begin
      errors++;
      $display("FAIL mr0_out: valid=%b block=%h last=%b required 1/%h/0",
               out_valid0, out_block0, out_last0, R1_OUT);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_valid0 = 1'b0;
    in_block = '0; in_round_key = '0; in_last = 1'b0;
    out_ready = 1'b1; out_ready0 = 1'b1;
    test_reset();
    test_round1();
    test_final_round();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_mid_reg0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
